// File: rtl/ppi_pkg.sv
// rtl/ppi_pkg.sv - shared constants and FSM state type for the 8255A Group A mode 1 controller
package ppi_pkg;

  localparam logic [1:0] ADDR_PA = 2'b00;
  localparam logic [1:0] ADDR_PB = 2'b01;
  localparam logic [1:0] ADDR_PC = 2'b10;
  localparam logic [1:0] ADDR_CW = 2'b11;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;

  localparam int CW_SET_BIT   = 7;
  localparam int CW_A_MODE_HI = 6;
  localparam int CW_A_MODE_LO = 5;
  localparam int CW_A_DIR     = 4;

  // Port C bit-set/reset selectors (din[3:1]) that address INTE_A
  localparam logic [2:0] BSR_INTE_A_IN  = 3'b100;
  localparam logic [2:0] BSR_INTE_A_OUT = 3'b110;

  typedef enum logic [1:0] {IDLE, FULL, BUSY, ACKD} state_e;

endpackage

// File: rtl/ppi_sync_edge.sv
// rtl/ppi_sync_edge.sv - multi-stage synchronizer for an asynchronous pin with rise/fall pulses
module ppi_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_out = sync_q[STAGES-1];
  assign rise     = ~prev_q & sync_q[STAGES-1];
  assign fall     = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/ppi_mode1_ctrl_a.sv
// rtl/ppi_mode1_ctrl_a.sv - 8255A Group A mode 1 strobed handshake controller (option: PPI_OVERRUN_EN)
module ppi_mode1_ctrl_a
  import ppi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  RESET_CW    = 8'h9B
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       dout_en,
  input  logic [7:0] pa_in,
  output logic [7:0] pa_out,
  output logic       pa_oe,
  input  logic       stb_n,
  input  logic       ack_n,
  output logic       ibf,
  output logic       obf_n,
  output logic       intr,
  output logic       mode1_act
);

  logic [7:0] cw_q, cw_d;
  logic [7:0] pa_out_q, pa_out_d;
  logic [7:0] pa_latch_q, pa_latch_d;
  state_e     state_q, state_d;
  logic       ibf_q, ibf_d;
  logic       obf_n_q, obf_n_d;
  logic       intr_q, intr_d;
  logic       inte_q, inte_d;
  logic       wr_prev_q, rd_prev_q;
  logic       ovr_bit;
  logic       cw_unused;

  logic stb_s, stb_rise, stb_fall;
  logic ack_s, ack_rise, ack_fall;

  ppi_sync_edge #(.STAGES(SYNC_STAGES)) u_stb_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (stb_n),
    .sync_out (stb_s),
    .rise     (stb_rise),
    .fall     (stb_fall)
  );

  ppi_sync_edge #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (ack_n),
    .sync_out (ack_s),
    .rise     (ack_rise),
    .fall     (ack_fall)
  );

  logic in_mode, is_mode1, sel_pa, sel_cw;
  logic wr_commit, cw_wr, pa_wr, pa_wr_start, pa_rd_start, pa_rd_end;

  assign in_mode   = cw_q[CW_A_DIR];
  assign is_mode1  = (cw_q[CW_A_MODE_HI:CW_A_MODE_LO] == MODE1);
  assign cw_unused = ^cw_q[3:0] ^ cw_q[CW_SET_BIT];
  assign sel_pa    = ~cs_n & (addr == ADDR_PA);
  assign sel_cw    = ~cs_n & (addr == ADDR_CW);

  // Bus strobes are sampled every clock; commits happen on the trailing edge of wr_n
  assign wr_commit   = ~wr_prev_q & wr_n;
  assign cw_wr       = wr_commit & sel_cw;
  assign pa_wr       = wr_commit & sel_pa;
  assign pa_wr_start = wr_prev_q & ~wr_n & sel_pa;
  assign pa_rd_start = rd_prev_q & ~rd_n & sel_pa;
  assign pa_rd_end   = ~rd_prev_q & rd_n & sel_pa;

`ifdef PPI_OVERRUN_EN
  logic ovr_q, ovr_d;
  assign ovr_bit = ovr_q;
`else
  assign ovr_bit = 1'b0;
`endif

  always_comb begin
    cw_d       = cw_q;
    pa_out_d   = pa_out_q;
    pa_latch_d = pa_latch_q;
    state_d    = state_q;
    ibf_d      = ibf_q;
    obf_n_d    = obf_n_q;
    intr_d     = intr_q;
    inte_d     = inte_q;
`ifdef PPI_OVERRUN_EN
    ovr_d      = ovr_q;
`endif
    // A control write takes the whole cycle; any pin edge landing with it is dropped
    if (cw_wr) begin
      if (din[CW_SET_BIT]) begin
        cw_d     = din;
        state_d  = IDLE;
        ibf_d    = 1'b0;
        obf_n_d  = 1'b1;
        intr_d   = 1'b0;
        inte_d   = 1'b0;
        pa_out_d = 8'h00;
`ifdef PPI_OVERRUN_EN
        ovr_d    = 1'b0;
`endif
      end else if (is_mode1) begin
        if (in_mode && din[3:1] == BSR_INTE_A_IN) begin
          inte_d = din[0];
          intr_d = din[0] & ibf_q & stb_s;
        end else if (!in_mode && din[3:1] == BSR_INTE_A_OUT) begin
          inte_d = din[0];
          intr_d = din[0] & obf_n_q & ack_s;
        end
      end
    end else begin
      if (pa_wr && !in_mode) pa_out_d = din;
      if (is_mode1 && in_mode) begin
        case (state_q)
          IDLE: begin
            if (stb_fall) begin
              pa_latch_d = pa_in;
              ibf_d      = 1'b1;
              state_d    = FULL;
            end
          end
          FULL: begin
            if (stb_rise)    intr_d = inte_q;
            if (pa_rd_start) intr_d = 1'b0;
            if (pa_rd_end) begin
              ibf_d   = 1'b0;
              state_d = IDLE;
            end
`ifdef PPI_OVERRUN_EN
            if (stb_fall)    ovr_d = 1'b1;
`endif
          end
          default: ;
        endcase
      end else if (is_mode1) begin
        case (state_q)
          IDLE: begin
            if (pa_wr_start) intr_d = 1'b0;
            if (pa_wr) begin
              obf_n_d = 1'b0;
              state_d = BUSY;
            end
          end
          BUSY: begin
            if (ack_fall) begin
              obf_n_d = 1'b1;
              state_d = ACKD;
            end
`ifdef PPI_OVERRUN_EN
            if (pa_wr) ovr_d = 1'b1;
`endif
          end
          ACKD: begin
            if (ack_rise) begin
              intr_d  = inte_q;
              state_d = IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cw_q       <= RESET_CW;
      pa_out_q   <= 8'h00;
      pa_latch_q <= 8'h00;
      state_q    <= IDLE;
      ibf_q      <= 1'b0;
      obf_n_q    <= 1'b1;
      intr_q     <= 1'b0;
      inte_q     <= 1'b0;
      wr_prev_q  <= 1'b1;
      rd_prev_q  <= 1'b1;
`ifdef PPI_OVERRUN_EN
      ovr_q      <= 1'b0;
`endif
    end else begin
      cw_q       <= cw_d;
      pa_out_q   <= pa_out_d;
      pa_latch_q <= pa_latch_d;
      state_q    <= state_d;
      ibf_q      <= ibf_d;
      obf_n_q    <= obf_n_d;
      intr_q     <= intr_d;
      inte_q     <= inte_d;
      wr_prev_q  <= wr_n;
      rd_prev_q  <= rd_n;
`ifdef PPI_OVERRUN_EN
      ovr_q      <= ovr_d;
`endif
    end
  end

  assign dout_en = ~cs_n & ~rd_n & ((addr == ADDR_PA) | (addr == ADDR_PC));

  always_comb begin
    dout = 8'h00;
    if (dout_en) begin
      if (addr == ADDR_PA)  dout = in_mode ? pa_latch_q : pa_out_q;
      else if (in_mode)     dout = {2'b00, ibf_q, inte_q, intr_q, 2'b00, ovr_bit};
      else                  dout = {obf_n_q, inte_q, 2'b00, intr_q, 2'b00, ovr_bit};
    end
  end

  assign pa_out    = pa_out_q;
  assign pa_oe     = ~cw_q[CW_A_DIR];
  assign ibf       = ibf_q;
  assign obf_n     = obf_n_q;
  assign intr      = intr_q;
  assign mode1_act = is_mode1;

endmodule

// File: doc/ppi_mode1_ctrl_a.md
Name: ppi_mode1_ctrl_a

Overview:
- Group A Mode 1 (strobed I/O) handshake controller for the 8255A PPI.
- Holds the control word, the Port A data latch and the INTE_A flip-flop.
- Drives the Port C handshake pins PC3 (INTR_A), PC4/PC5 in input mode and PC6/PC7 in output mode.
- Sits between the CPU bus decode and the Port A/Port C pad logic. It sequences when Port A data is captured or presented, and when the CPU is interrupted.

Parameters:
- SYNC_STAGES, 2, flop stages on the asynchronous stb_n and ack_n pins (minimum 2).
- RESET_CW, 8'h9B, control word loaded at reset (mode 0, all ports input).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cs_n  in  1  chip select, active low, synchronous to clk.
- rd_n  in  1  read strobe, active low, synchronous.
- wr_n  in  1  write strobe, active low, synchronous.
- addr  in  2  register select: 00 = Port A, 10 = Port C, 11 = control.
- din  in  8  CPU write data.
- dout  out  8  CPU read data.
- dout_en  out  1  high while cs_n=0, rd_n=0 and addr is 00 or 10.
- pa_in  in  8  Port A pad input.
- pa_out  out  8  Port A output latch.
- pa_oe  out  1  Port A pad output enable.
- stb_n  in  1  PC4, strobe, asynchronous (input mode).
- ack_n  in  1  PC6, acknowledge, asynchronous (output mode).
- ibf  out  1  PC5, input buffer full.
- obf_n  out  1  PC7, output buffer full, active low.
- intr  out  1  PC3, INTR_A.
- mode1_act  out  1  high when cw[6:5]=01; Port C logic yields PC3..PC7 to this block.

Behaviour:
- Clock/reset: single clock domain. reset_n asynchronous, active-low.
- Reset values:
  - cw=RESET_CW; pa_out=0; pa_oe=0.
  - ibf=0; obf_n=1; intr=0; inte=0.
  - dout=0; dout_en=0.
  - FSM=IDLE; all synchronizers at 1.
- Event detection:
  - CPU write commits on the rising edge of wr_n (previous sample 0, current 1) with cs_n=0.
  - Read start = falling edge of rd_n; read end = rising edge of rd_n; both qualified by cs_n=0 and addr.
  - stb_n and ack_n edges are detected after the synchronizer. Pin-to-state latency = SYNC_STAGES+1 cycles.
- Control writes (addr=11):
  - din[7]=1: cw<=din. FSM returns to IDLE. ibf=0, obf_n=1, intr=0, inte=0, pa_out=0.
  - din[7]=0 (BSR):
    - Input mode: din[3:1]=100 sets inte<=din[0].
    - Output mode: din[3:1]=110 sets inte<=din[0].
    - Other bits are ignored here and handled by Port C logic.
    - intr is re-evaluated the next cycle as input: ibf & inte & stb_sync; output: ~obf_n? no: obf_n & inte & ack_sync (see below).
- Direction:
  - mode1_act=(cw[6:5]==01). When low, handshake outputs hold reset values.
  - pa_oe=~cw[4].
- Input mode (mode1_act, cw[4]=1):
  - IDLE: stb falling -> pa_latch<=pa_in, ibf<=1, go FULL.
  - FULL: stb rising -> intr<=inte.
  - FULL: Port A read start -> intr<=0.
  - FULL: Port A read end -> ibf<=0, go IDLE.
  - stb falling in FULL is ignored; the latch is not overwritten.
- Output mode (mode1_act, cw[4]=0):
  - IDLE: Port A write start (wr_n falling) -> intr<=0.
  - IDLE: Port A write commit -> pa_out<=din, obf_n<=0, go BUSY.
  - BUSY: ack falling -> obf_n<=1, go ACKD.
  - ACKD: ack rising -> intr<=inte, go IDLE.
  - A Port A write in BUSY updates pa_out and leaves obf_n=0.
- Port C read (addr=10):
  - Input mode: dout={2'b00, ibf, inte, intr, 3'b000}.
  - Output mode: dout={obf_n, inte, 2'b00, intr, 3'b000}.
- Port A read (addr=00): dout=pa_latch in input mode, pa_out otherwise.
- Simultaneous events: a control write in the same cycle as any pin edge wins; the pin edge is discarded.
- Reset mid-transfer: all state clears immediately, asynchronously.

Optional Feature:
- Macro PPI_OVERRUN_EN.
- Defined:
  - A sticky ovr flag sets on stb falling while in FULL (input) or on a Port A write while in BUSY (output).
  - ovr is readable at Port C read bit 0.
  - ovr clears on a control-word write (din[7]=1) or reset.
- Undefined: no flag; bit 0 reads 0.

Decomposition:
- Package ppi_pkg holds:
  - address constants ADDR_PA/ADDR_PB/ADDR_PC/ADDR_CW.
  - mode encodings MODE0/MODE1/MODE2.
  - cw bit-index constants.
  - the FSM state enum {IDLE, FULL, BUSY, ACKD}.
- One sub-module, ppi_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse outputs. Instantiated for stb_n and ack_n.

Test Plan:
- Reset -> cw=9B, ibf=0, obf_n=1, intr=0, pa_oe=0, mode1_act=0.
- Write cw=B0, BSR 09 (INTE set), pa_in=5A, pulse stb_n -> ibf=1 after SYNC_STAGES+1 cycles; intr=1 after stb_n rises; Port A read returns 5A; intr=0 at rd_n fall; ibf=0 at rd_n rise.
- Write cw=A0, BSR 0D, Port A write C3 -> pa_out=C3, pa_oe=1, obf_n=0; ack_n low -> obf_n=1; ack_n high -> intr=1; next write clears intr at wr_n fall.
- With INTE=0 (BSR 08), a full input handshake -> intr stays 0; Port C read shows ibf=1, inte=0.
- Second stb in FULL with pa_in=11 after 5A latched -> Port A read returns 5A; with PPI_OVERRUN_EN, Port C read bit0=1.
- reset_n asserted in FULL with ibf=1, intr=1 -> both 0 asynchronously; the control word write B0 during BUSY returns FSM to IDLE, obf_n=1.
